// File: rtl/pll_clock_sequencer.sv
// pll_clock_sequencer
// Brings the on-chip PLL up from the boot clock. The sequence is:
// enable the PLL, wait for lock (with a timeout), require a settle window
// of continuous lock, then release the four derived clock gates one at a time.
// On loss of lock the gates are shut and the PLL is power-cycled. After
// MAX_RETRIES failed retries the block parks in FAULT.
// Every output is a flop. Its next value is derived from the state the FSM is
// about to enter, so outputs change in the same cycle as the state they belong to.
// There is no valid/ready handshake here: start is a plain level request and
// pll_lock is a raw asynchronous status.
module pll_clock_sequencer #(
   parameter int LOCK_TIMEOUT   = 1024,
   parameter int SETTLE_CYCLES  = 256,
   parameter int STAGGER_CYCLES = 16,
   parameter int OFF_CYCLES     = 64,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pll_lock,
   output logic       pll_en,
   output logic [3:0] clk_gate_en,
   output logic       ready,
   output logic       fault,
   output logic       lost_lock,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PWRUP  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_ENABLE = 3'd3,
      ST_RUN    = 3'd4,
      ST_OFF    = 3'd5,
      ST_FAULT  = 3'd6
   } state_t;

   // The timer is sized to the longest interval it ever has to measure.
   // The extra bit gives headroom, so the saturating increment never wraps.
   localparam int T_A   = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
   localparam int T_B   = ((4 * STAGGER_CYCLES) > OFF_CYCLES) ? (4 * STAGGER_CYCLES) : OFF_CYCLES;
   localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
   localparam int TW    = $clog2(T_MAX) + 1;

   localparam logic [TW-1:0] LOCK_LAST    = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LAST     = TW'(OFF_CYCLES - 1);
   localparam logic [TW-1:0] T_ONE        = TW'(1);
   localparam logic [TW-1:0] T_SAT        = {TW{1'b1}};
   localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

   state_t          state_q;
   state_t          state_d;
   logic [TW-1:0]   timer;
   logic [TW-1:0]   timer_d;
   logic [TW-1:0]   timer_inc;
   logic [7:0]      retry_cnt;
   logic [7:0]      retry_d;
   logic            lock_meta;
   logic            lock_s;
   logic            pll_en_d;
   logic [3:0]      gate_d;
   logic [3:0]      gate_adv;
   logic            ready_d;
   logic            fault_d;
   logic            lost_d;

   assign state = state_q;

   // Two-flop synchronizer bringing the raw PLL lock into the boot clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

   // State, counter and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         timer       <= '0;
         retry_cnt   <= 8'd0;
         pll_en      <= 1'b0;
         clk_gate_en <= 4'b0000;
         ready       <= 1'b0;
         fault       <= 1'b0;
         lost_lock   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer       <= timer_d;
         retry_cnt   <= retry_d;
         pll_en      <= pll_en_d;
         clk_gate_en <= gate_d;
         ready       <= ready_d;
         fault       <= fault_d;
         lost_lock   <= lost_d;
      end
   end

   // Next-state, counter updates, and output values for the state being entered.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer;
      retry_d   = retry_cnt;
      lost_d    = 1'b0;
      gate_adv  = clk_gate_en;
      timer_inc = (timer == T_SAT) ? timer : (timer + T_ONE);
      pll_en_d  = 1'b0;
      gate_d    = 4'b0000;
      ready_d   = 1'b0;
      fault_d   = 1'b0;

      // Dropping start is an orderly shutdown from any active state.
      // It overrides every other transition.
      if (!start && (state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_PWRUP;
                  timer_d = '0;
                  retry_d = 8'd0;
               end
            end
            ST_PWRUP: begin
               if (lock_s) begin
                  state_d = ST_SETTLE;
                  timer_d = '0;
               end else if (timer == LOCK_LAST) begin
                  state_d = ST_OFF;
                  timer_d = '0;
               end else begin
                  timer_d = timer_inc;
               end
            end
            ST_SETTLE: begin
               // A lock glitch restarts the lock wait. It does not consume a retry.
               if (!lock_s) begin
                  state_d = ST_PWRUP;
                  timer_d = '0;
               end else if (timer == SETTLE_LAST) begin
                  state_d = ST_ENABLE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_inc;
               end
            end
            ST_ENABLE: begin
               if (!lock_s) begin
                  state_d = ST_OFF;
                  timer_d = '0;
                  lost_d  = 1'b1;
               end else if (clk_gate_en[3]) begin
                  state_d = ST_RUN;
                  timer_d = '0;
               end else if (timer == STAGGER_LAST) begin
                  // Fill the gate mask from bit 0 upward: 0001 -> 0011 -> 0111 -> 1111.
                  gate_adv = {clk_gate_en[2:0], 1'b1};
                  timer_d  = '0;
               end else begin
                  timer_d = timer_inc;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d = ST_OFF;
                  timer_d = '0;
                  lost_d  = 1'b1;
               end
            end
            ST_OFF: begin
               if (timer == OFF_LAST) begin
                  timer_d = '0;
                  if (retry_cnt == RETRY_LIMIT) begin
                     state_d = ST_FAULT;
                  end else begin
                     state_d = ST_PWRUP;
                     retry_d = (retry_cnt == 8'hFF) ? retry_cnt : (retry_cnt + 8'd1);
                  end
               end else begin
                  timer_d = timer_inc;
               end
            end
            ST_FAULT: begin
               if (!start) begin
                  state_d = ST_IDLE;
                  timer_d = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         endcase
      end

      // Output values belong to the destination state, so they register
      // in the same cycle as the state itself.
      case (state_d)
         ST_PWRUP, ST_SETTLE: begin
            pll_en_d = 1'b1;
         end
         ST_ENABLE: begin
            pll_en_d = 1'b1;
            gate_d   = (state_q == ST_ENABLE) ? gate_adv : 4'b0001;
         end
         ST_RUN: begin
            pll_en_d = 1'b1;
            gate_d   = 4'b1111;
            ready_d  = 1'b1;
         end
         ST_FAULT: begin
            fault_d = 1'b1;
         end
         default: begin
            pll_en_d = 1'b0;
         end
      endcase
   end

endmodule
